// File: rtl/prog_mem_pkg.sv
// Shared processor package: fetch-unit state encoding, default NOP
// instruction word and small sizing helpers used by the program memory
// and the decode/execute blocks.
package prog_mem_pkg;

  // Program memory controller states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } pm_state_t;

  // Default instruction word returned for cleared or out-of-range words
  localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

  // Index width needed to address 'depth' words (at least one bit)
  function automatic int idx_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/prog_mem_if.sv
// Fetch / program-load bus between an instruction fetch unit (master) and
// the program memory (slave).
interface prog_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/prog_mem_array.sv
// Instruction storage: one synchronous write port and one registered read
// port. The array carries no reset; its contents are initialised by the
// controller's clear sequence.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Write port: the controller only presents in-range addresses
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port: holds its value until the next enabled read
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Program memory with a fetch request/response handshake and a program-load
// write port. After reset every word is overwritten with NOP_WORD, one word
// per cycle, before fetches or loads are serviced.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                 DATA_W   = 16,
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 256,
  parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic       clk,
  input  logic       rst_n,
  prog_mem_if.slave  bus
);

  localparam int               IDX_W    = idx_width(DEPTH);
  // One extra bit so that DEPTH == 2**ADDR_W is still representable
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
  localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

  pm_state_t         state_r;
  logic [IDX_W-1:0]  cnt_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic              rsp_err_r;

  logic              req_in_range_s;
  logic              ld_in_range_s;
  logic              req_ready_s;
  logic              accept_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic              rd_en_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] rsp_data_s;

  // Unsigned range checks at ADDR_W+1 bits
  assign req_in_range_s = ({1'b0, bus.req_addr} < DEPTH_X);
  assign ld_in_range_s  = ({1'b0, bus.ld_addr}  < DEPTH_X);

  // Fetch readiness: loads win, and a pending response must drain first
  always_comb begin
    req_ready_s = 1'b0;
    if (state_r == ST_RUN) begin
      req_ready_s = !bus.ld_en && (!rsp_valid_r || bus.rsp_ready);
    end else begin
      req_ready_s = 1'b0;
    end
  end

  assign accept_s = bus.req_valid && req_ready_s;
  // Out-of-range fetches never touch the array; the response is forced to NOP
  assign rd_en_s  = accept_s && req_in_range_s;

  // Write-port steering: clear counter during CLEAR, load port during RUN
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = ZERO_IDX;
    wr_data_s = NOP_WORD;
    case (state_r)
      ST_CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = cnt_r;
        wr_data_s = NOP_WORD;
      end
      ST_RUN: begin
        if (bus.ld_en && ld_in_range_s) begin
          wr_en_s   = 1'b1;
          wr_addr_s = bus.ld_addr[IDX_W-1:0];
          wr_data_s = bus.ld_data;
        end else begin
          wr_en_s   = 1'b0;
          wr_addr_s = ZERO_IDX;
          wr_data_s = NOP_WORD;
        end
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = ZERO_IDX;
        wr_data_s = NOP_WORD;
      end
    endcase
  end

  prog_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_en   (rd_en_s),
    .rd_addr (bus.req_addr[IDX_W-1:0]),
    .rd_data (rd_data_s)
  );

  // Controller FSM: clear sweep, then fetch response tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_CLEAR;
      cnt_r       <= ZERO_IDX;
      busy_r      <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          if (cnt_r == LAST_IDX) begin
            // Counter parks on the last index; it never wraps
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            cnt_r  <= cnt_r + ONE_IDX;
            busy_r <= 1'b1;
          end
        end
        ST_RUN: begin
          busy_r <= 1'b0;
          if (accept_s) begin
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= !req_in_range_s;
          end else if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
          end else begin
            rsp_valid_r <= rsp_valid_r;
            rsp_err_r   <= rsp_err_r;
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          cnt_r       <= ZERO_IDX;
          busy_r      <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Response data: array word for a valid in-range fetch, otherwise NOP
  always_comb begin
    rsp_data_s = NOP_WORD;
    if (rsp_valid_r && !rsp_err_r) begin
      rsp_data_s = rd_data_s;
    end else begin
      rsp_data_s = NOP_WORD;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.rsp_data  = rsp_data_s;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_prog_mem.sv
// Directed self-checking bench for prog_mem: a DEPTH=256 instance with the
// default NOP word and a DEPTH=16 instance with a non-zero NOP word.
module tb_prog_mem;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   n16;
  int   n256;
  int   nrsp;
  bit   rdy_seen;
  bit   rdy_ok;

  prog_mem_if #(.DATA_W(16), .ADDR_W(8)) b256 ();
  prog_mem_if #(.DATA_W(16), .ADDR_W(8)) b16 ();

  prog_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .NOP_WORD(16'h0000)) dut256 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b256)
  );

  prog_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(16), .NOP_WORD(16'hE000)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count busy cycles of both instances (bounded), noting any req_ready while busy
  task automatic wait_clear(output int c16, output int c256, output bit seen);
    c16  = 0;
    c256 = 0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (b16.busy === 1'b1) begin
        c16++;
        if (b16.req_ready !== 1'b0) seen = 1'b1;
      end
      if (b256.busy === 1'b1) begin
        c256++;
        if (b256.req_ready !== 1'b0) seen = 1'b1;
      end
      if (b16.busy !== 1'b1 && b256.busy !== 1'b1) break;
    end
  endtask

  task automatic fetch16(input logic [7:0] a, input logic [15:0] ed, input logic ee, input string tag);
    b16.req_valid = 1'b1;
    b16.req_addr  = a;
    b16.rsp_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(b16.req_ready), 32'h1);
    @(posedge clk); #1;
    b16.req_valid = 1'b0;
    #1;
    check({tag, "_vld"}, 32'(b16.rsp_valid), 32'h1);
    check({tag, "_data"}, 32'(b16.rsp_data), 32'(ed));
    check({tag, "_err"}, 32'(b16.rsp_err), 32'(ee));
  endtask

  task automatic fetch256(input logic [7:0] a, input logic [15:0] ed, input logic ee, input string tag);
    b256.req_valid = 1'b1;
    b256.req_addr  = a;
    b256.rsp_ready = 1'b1;
    #1 check({tag, "_rdy"}, 32'(b256.req_ready), 32'h1);
    @(posedge clk); #1;
    b256.req_valid = 1'b0;
    #1;
    check({tag, "_vld"}, 32'(b256.rsp_valid), 32'h1);
    check({tag, "_data"}, 32'(b256.rsp_data), 32'(ed));
    check({tag, "_err"}, 32'(b256.rsp_err), 32'(ee));
  endtask

  task automatic load16(input logic [7:0] a, input logic [15:0] d);
    b16.ld_en   = 1'b1;
    b16.ld_addr = a;
    b16.ld_data = d;
    #1 check("load16_rdy0", 32'(b16.req_ready), 32'h0);
    @(posedge clk); #1;
    b16.ld_en = 1'b0;
  endtask

  task automatic load256(input logic [7:0] a, input logic [15:0] d);
    b256.ld_en   = 1'b1;
    b256.ld_addr = a;
    b256.ld_data = d;
    #1 check("load256_rdy0", 32'(b256.req_ready), 32'h0);
    @(posedge clk); #1;
    b256.ld_en = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    b256.req_valid = 1'b0; b256.req_addr = 8'h00; b256.rsp_ready = 1'b0;
    b256.ld_en = 1'b0; b256.ld_addr = 8'h00; b256.ld_data = 16'h0000;
    b16.req_valid = 1'b0; b16.req_addr = 8'h00; b16.rsp_ready = 1'b0;
    b16.ld_en = 1'b0; b16.ld_addr = 8'h00; b16.ld_data = 16'h0000;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(b256.busy), 32'h1);
    check("rst_req_ready", 32'(b256.req_ready), 32'h0);
    check("rst_rsp_valid", 32'(b256.rsp_valid), 32'h0);
    check("rst_rsp_data", 32'(b256.rsp_data), 32'h0000);
    check("rst_rsp_err", 32'(b256.rsp_err), 32'h0);
    check("rst_rsp_data16", 32'(b16.rsp_data), 32'h0000E000);

    // Release reset; hammer the DEPTH=256 instance with ignored traffic during CLEAR
    @(posedge clk); #1;
    rst_n = 1'b1;
    b256.ld_en = 1'b1; b256.ld_addr = 8'h05; b256.ld_data = 16'hFFFF;
    b256.req_valid = 1'b1; b256.req_addr = 8'h05;
    wait_clear(n16, n256, rdy_seen);
    b256.ld_en = 1'b0;
    b256.req_valid = 1'b0;
    check("clear_cycles256", 32'(n256), 32'd256);
    check("clear_cycles16", 32'(n16), 32'd16);
    check("clear_ready_low", 32'(rdy_seen), 32'h0);
    check("clear_no_rsp", 32'(b256.rsp_valid), 32'h0);

    // Cleared words read back as zero; the load during CLEAR was ignored
    fetch256(8'h00, 16'h0000, 1'b0, "clr_a00");
    fetch256(8'h05, 16'h0000, 1'b0, "clr_a05");
    fetch256(8'hFF, 16'h0000, 1'b0, "clr_aFF");

    // Load then fetch the same address on the next cycle
    load256(8'h01, 16'hC800);
    fetch256(8'h01, 16'hC800, 1'b0, "ld_fetch01");

    // Out-of-range fetch and dropped loads on DEPTH=16
    fetch16(8'h20, 16'hE000, 1'b1, "oor20");
    load16(8'h20, 16'h1234);
    load16(8'h10, 16'h5678);
    fetch16(8'h00, 16'hE000, 1'b0, "no_alias00");
    load16(8'h0F, 16'hBEEF);
    fetch16(8'h0F, 16'hBEEF, 1'b0, "last_word");
    fetch16(8'h10, 16'hE000, 1'b1, "oor10");

    // Fill the small memory, then stream 16 back-to-back fetches
    for (int i = 0; i < 16; i++) begin
      load16(8'(i), 16'hA000 + 16'(i));
    end
    nrsp   = 0;
    rdy_ok = 1'b1;
    b16.rsp_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      b16.req_valid = (c < 16);
      b16.req_addr  = 8'(c);
      @(negedge clk);
      if (c < 16 && b16.req_ready !== 1'b1) rdy_ok = 1'b0;
      if (b16.rsp_valid === 1'b1) begin
        check("stream_data", 32'(b16.rsp_data), 32'(16'hA000 + 16'(nrsp)));
        nrsp++;
      end
      @(posedge clk); #1;
    end
    b16.req_valid = 1'b0;
    check("stream_count", 32'(nrsp), 32'd16);
    check("stream_ready", 32'(rdy_ok), 32'h1);

    // Back-pressure: response holds while rsp_ready is low
    b16.rsp_ready = 1'b0;
    b16.req_valid = 1'b1;
    b16.req_addr  = 8'h03;
    @(posedge clk); #1;
    b16.req_addr  = 8'h04;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_vld", 32'(b16.rsp_valid), 32'h1);
      check("stall_data", 32'(b16.rsp_data), 32'h0000A003);
      check("stall_rdy", 32'(b16.req_ready), 32'h0);
      @(posedge clk); #1;
    end
    b16.rsp_ready = 1'b1;
    #1 check("unstall_rdy", 32'(b16.req_ready), 32'h1);
    @(posedge clk); #1;
    b16.req_valid = 1'b0;
    #1;
    check("unstall_vld", 32'(b16.rsp_valid), 32'h1);
    check("unstall_data", 32'(b16.rsp_data), 32'h0000A004);
    @(posedge clk); #2;
    check("drain_vld", 32'(b16.rsp_valid), 32'h0);

    // Load and fetch requested together: load wins, fetch follows
    b16.ld_en = 1'b1; b16.ld_addr = 8'h07; b16.ld_data = 16'h7777;
    b16.req_valid = 1'b1; b16.req_addr = 8'h07;
    #1 check("ldpri_rdy0", 32'(b16.req_ready), 32'h0);
    @(posedge clk); #1;
    b16.ld_en = 1'b0;
    #1;
    check("ldpri_no_rsp", 32'(b16.rsp_valid), 32'h0);
    check("ldpri_rdy1", 32'(b16.req_ready), 32'h1);
    @(posedge clk); #1;
    b16.req_valid = 1'b0;
    #1;
    check("ldpri_vld", 32'(b16.rsp_valid), 32'h1);
    check("ldpri_data", 32'(b16.rsp_data), 32'h00007777);

    // Reset with a response pending, then again in the middle of CLEAR
    b16.rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("pend_vld", 32'(b16.rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_vld", 32'(b16.rsp_valid), 32'h0);
    check("arst_data", 32'(b16.rsp_data), 32'h0000E000);
    check("arst_err", 32'(b16.rsp_err), 32'h0);
    check("arst_busy", 32'(b16.busy), 32'h1);
    check("arst_rdy", 32'(b16.req_ready), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midclr_busy", 32'(b16.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midclr_rst_busy", 32'(b16.busy), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_clear(n16, n256, rdy_seen);
    check("reclear_cycles16", 32'(n16), 32'd16);
    check("reclear_cycles256", 32'(n256), 32'd256);
    check("reclear_ready_low", 32'(rdy_seen), 32'h0);

    // Memory contents restored by the new CLEAR sweep
    fetch16(8'h07, 16'hE000, 1'b0, "reclr07");
    fetch256(8'h01, 16'h0000, 1'b0, "reclr01");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 The module SHALL have these parameters:
- DATA_W, default 16, instruction width in bits.
- ADDR_W, default 8, address width in bits.
- DEPTH, default 256, number of words; DEPTH SHALL be no greater than 2**ADDR_W.
- NOP_WORD, default all-zero, value returned for cleared or out-of-range words.
REQ-002 The module SHALL have these ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  fetch request accepted this cycle.
- req_addr  in  ADDR_W  fetch address.
- rsp_valid  out  1  fetch response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  fetched instruction.
- rsp_err  out  1  fetch address was >= DEPTH.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  ADDR_W  load address.
- ld_data  in  DATA_W  load data.
- busy  out  1  clear sequence in progress.

Function
REQ-003 States SHALL be CLEAR and RUN.
REQ-004 Reset SHALL enter CLEAR; CLEAR SHALL write NOP_WORD to addresses 0..DEPTH-1, one per cycle, via an internal counter, and go to RUN after writing DEPTH-1, so busy=1 for exactly DEPTH cycles.
REQ-005 In CLEAR, req_ready SHALL be 0 and ld_en SHALL be ignored.
REQ-006 In RUN, a fetch SHALL be accepted when req_valid && req_ready.
REQ-007 In RUN, req_ready SHALL be 1 when ld_en=0 and (rsp_valid=0 or rsp_ready=1), giving single-entry buffering with full throughput.
REQ-008 An accepted fetch SHALL present rsp_valid=1 with rsp_data and rsp_err on the next cycle (1-cycle latency).
REQ-009 rsp_valid, rsp_data and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-010 rsp_valid SHALL clear after a response handshake when no new fetch is accepted in the same cycle.
REQ-011 For req_addr >= DEPTH, rsp_data SHALL be NOP_WORD and rsp_err SHALL be 1; otherwise rsp_err SHALL be 0.
REQ-012 In RUN, ld_en=1 with ld_addr < DEPTH SHALL write ld_data at the clock edge; ld_addr >= DEPTH SHALL be dropped silently.
REQ-013 ld_en SHALL take priority over fetch: req_ready=0 in any cycle with ld_en=1, so a load and a fetch never complete in the same cycle.
REQ-014 A fetch accepted the cycle after a load to the same address SHALL return the new data.
REQ-015 The address counter SHALL not wrap past DEPTH-1.
REQ-016 All address comparisons SHALL be unsigned at ADDR_W bits, and the counter SHALL be wide enough to hold DEPTH-1 without overflow.

Reset
REQ-017 Asserting rst_n low at any time, including mid-CLEAR or while a response is pending, SHALL immediately set state=CLEAR, counter=0, busy=1, req_ready=0, rsp_valid=0, rsp_data=NOP_WORD and rsp_err=0.
REQ-018 Any pending response SHALL be discarded on reset.
REQ-019 Memory contents SHALL be restored only by the post-reset CLEAR sequence, not by the asynchronous reset itself.

Structure
REQ-020 The state enum and the default NOP_WORD constant SHALL live in the shared processor package used by the decode/execute blocks.
REQ-021 The storage array SHALL be one sub-module, prog_mem_array: a single write port and a registered read port, with no reset on the array.

Verification
REQ-022 A bench SHALL cover these directed scenarios:
- Reset release, DEPTH=256 -> busy high exactly 256 cycles, req_ready=0 throughout, then every fetch returns 0x0000.
- Load 0xC800 at 0x01, then fetch 0x01 on the next cycle -> rsp_data=0xC800 one cycle after acceptance, rsp_err=0.
- DEPTH=16, fetch 0x20 -> rsp_data=NOP_WORD, rsp_err=1; load to 0x20 -> no array write.
- Back-to-back fetches 0x00..0x0F with rsp_ready=1 -> 16 responses in 17 cycles; with rsp_ready held 0 for 3 cycles -> response stable, req_ready=0.
- ld_en and req_valid asserted together -> req_ready=0, write completes, fetch accepted the following cycle.
- rst_n pulsed low mid-CLEAR and again with rsp_valid=1 -> rsp_valid drops immediately, CLEAR restarts from address 0.
